// File: rtl/branch_target_buffer_sa_if.sv
// Fetch/execute-side bundle for the branch target buffer:
// flush, lookup request/response and resolved-branch update.
interface branch_target_buffer_sa_if #(
    parameter int XLEN = 32
) ();
    logic            flush_i;
    logic            lookup_valid_i;
    logic [XLEN-1:0] lookup_pc_i;
    logic            lookup_valid_o;
    logic            lookup_hit_o;
    logic            lookup_taken_o;
    logic [XLEN-1:0] lookup_target_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_taken_i;

    // Pipeline side: issues lookups/updates, consumes predictions.
    modport master (
        output flush_i, lookup_valid_i, lookup_pc_i,
        output upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        input  lookup_valid_o, lookup_hit_o, lookup_taken_o, lookup_target_o
    );

    // Buffer side.
    modport slave (
        input  flush_i, lookup_valid_i, lookup_pc_i,
        input  upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i,
        output lookup_valid_o, lookup_hit_o, lookup_taken_o, lookup_target_o
    );
endinterface

// File: rtl/branch_target_buffer_sa.sv
// Set-associative branch target buffer for the maverickOne fetch stage.
// Registered lookup (1 cycle, read-before-write), update port from execute
// that trains 2-bit counters on hits and allocates on taken misses with a
// per-set round-robin victim pointer. Single-cycle flush of all entries.
package maverickOne_pkg;
    parameter int XLEN = 32;
endpackage

module branch_target_buffer_sa #(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 2,
    parameter int XLEN     = maverickOne_pkg::XLEN
) (
    input  logic clk_i,
    input  logic arst_ni,
    branch_target_buffer_sa_if.slave btb_if
);
    localparam int IDXW = $clog2(NUM_SETS);
    localparam int TAGW = XLEN - 2 - IDXW;
    localparam int TGTW = XLEN - 2;
    localparam int WAYW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    // Table state; only valid bits and victim pointers need a reset value.
    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [WAYW-1:0]     r_ptr   [NUM_SETS];
    logic [TAGW-1:0]     r_tag   [NUM_SETS][NUM_WAYS];
    logic [TGTW-1:0]     r_tgt   [NUM_SETS][NUM_WAYS];
    logic [1:0]          r_ctr   [NUM_SETS][NUM_WAYS];

    logic            r_lk_valid;
    logic            r_lk_hit;
    logic            r_lk_taken;
    logic [XLEN-1:0] r_lk_target;

    logic [IDXW-1:0]     w_lk_idx;
    logic [TAGW-1:0]     w_lk_tag;
    logic [NUM_WAYS-1:0] w_lk_match;
    logic [WAYW-1:0]     w_lk_way;
    logic                w_lk_hit;

    logic [IDXW-1:0]     w_up_idx;
    logic [TAGW-1:0]     w_up_tag;
    logic [NUM_WAYS-1:0] w_up_match;
    logic [WAYW-1:0]     w_up_way;
    logic                w_up_hit;
    logic                w_inv_found;
    logic [WAYW-1:0]     w_inv_way;
    logic [WAYW-1:0]     w_victim;
    logic [WAYW-1:0]     w_ptr_next;
    logic                w_alloc;
    logic                w_train;
    logic                w_unused;

    assign w_lk_idx = btb_if.lookup_pc_i[2 +: IDXW];
    assign w_lk_tag = btb_if.lookup_pc_i[XLEN-1:2+IDXW];
    assign w_up_idx = btb_if.upd_pc_i[2 +: IDXW];
    assign w_up_tag = btb_if.upd_pc_i[XLEN-1:2+IDXW];

    // Byte-offset bits are never stored or compared.
    assign w_unused = ^{btb_if.lookup_pc_i[1:0], btb_if.upd_pc_i[1:0], btb_if.upd_target_i[1:0]};

    // Lookup tag compare across all ways of the indexed set.
    always_comb begin
        w_lk_match = '0;
        w_lk_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag)) begin
                w_lk_match[w] = 1'b1;
                w_lk_way      = WAYW'(w);
            end
        end
    end
    assign w_lk_hit = |w_lk_match;

    // Update tag compare plus victim choice: lowest invalid way, else round-robin.
    always_comb begin
        w_up_match  = '0;
        w_up_way    = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag)) begin
                w_up_match[w] = 1'b1;
                w_up_way      = WAYW'(w);
            end
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_up_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAYW'(w);
            end
        end
    end
    assign w_up_hit   = |w_up_match;
    assign w_victim   = w_inv_found ? w_inv_way : r_ptr[w_up_idx];
    assign w_ptr_next = (r_ptr[w_up_idx] == WAYW'(NUM_WAYS - 1)) ? '0 : r_ptr[w_up_idx] + 1'b1;

    // A same-cycle flush drops the update entirely.
    assign w_alloc = btb_if.upd_valid_i && !w_up_hit && btb_if.upd_taken_i && !btb_if.flush_i;
    assign w_train = btb_if.upd_valid_i && w_up_hit && !btb_if.flush_i;

    // Valid bits and victim pointers: cleared by reset or flush, set on allocation.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (btb_if.flush_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else if (w_alloc) begin
            r_valid[w_up_idx][w_victim] <= 1'b1;
            if (!w_inv_found) begin
                r_ptr[w_up_idx] <= w_ptr_next;
            end
        end
    end

    // Entry payload: counter training on hits, fresh weakly-taken entry on allocation.
    always_ff @(posedge clk_i) begin
        if (w_train) begin
            if (btb_if.upd_taken_i) begin
                if (r_ctr[w_up_idx][w_up_way] != 2'b11) begin
                    r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] + 2'b01;
                end
                r_tgt[w_up_idx][w_up_way] <= btb_if.upd_target_i[XLEN-1:2];
            end else if (r_ctr[w_up_idx][w_up_way] != 2'b00) begin
                r_ctr[w_up_idx][w_up_way] <= r_ctr[w_up_idx][w_up_way] - 2'b01;
            end
        end else if (w_alloc) begin
            r_tag[w_up_idx][w_victim] <= w_up_tag;
            r_tgt[w_up_idx][w_victim] <= btb_if.upd_target_i[XLEN-1:2];
            r_ctr[w_up_idx][w_victim] <= 2'b10;
        end
    end

    // Registered prediction from pre-edge table contents; all zero when no request.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_lk_valid  <= 1'b0;
            r_lk_hit    <= 1'b0;
            r_lk_taken  <= 1'b0;
            r_lk_target <= '0;
        end else begin
            r_lk_valid  <= btb_if.lookup_valid_i;
            r_lk_hit    <= btb_if.lookup_valid_i && w_lk_hit;
            r_lk_taken  <= btb_if.lookup_valid_i && w_lk_hit && r_ctr[w_lk_idx][w_lk_way][1];
            r_lk_target <= (btb_if.lookup_valid_i && w_lk_hit) ? {r_tgt[w_lk_idx][w_lk_way], 2'b00} : '0;
        end
    end

    assign btb_if.lookup_valid_o  = r_lk_valid;
    assign btb_if.lookup_hit_o    = r_lk_hit;
    assign btb_if.lookup_taken_o  = r_lk_taken;
    assign btb_if.lookup_target_o = r_lk_target;

    // A tag may live in at most one way of its set.
    a_lk_onehot: assert property (@(posedge clk_i) disable iff (!arst_ni) $onehot0(w_lk_match))
        else $error("btb: multiple ways hit on lookup");
    a_up_onehot: assert property (@(posedge clk_i) disable iff (!arst_ni) $onehot0(w_up_match))
        else $error("btb: multiple ways hit on update");

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Scoreboard bench for branch_target_buffer_sa: directed scenarios then
// random traffic, predictions checked against an array-based reference model.
module tb_branch_target_buffer_sa;
    localparam int NS   = 16;
    localparam int NW   = 2;
    localparam int IDXW = 4;

    logic clk_i = 1'b0;
    logic arst_ni = 1'b0;

    branch_target_buffer_sa_if #(.XLEN(32)) bif ();

    branch_target_buffer_sa #(.NUM_SETS(NS), .NUM_WAYS(NW), .XLEN(32)) dut (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .btb_if (bif)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          v;
        bit          h;
        bit          t;
        logic [31:0] tg;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: per set/way state described directly from the rules.
    bit          m_valid [NS][NW];
    logic [31:0] m_tag   [NS][NW];
    logic [31:0] m_tgt   [NS][NW];
    int          m_ctr   [NS][NW];
    int          m_rr    [NS];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        for (int s = 0; s < NS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < NW; w++) m_valid[s][w] = 0;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output exp_t e);
        int s;
        logic [31:0] tg;
        s    = int'((pc >> 2) % NS);
        tg   = pc >> (2 + IDXW);
        e.v  = 1;
        e.h  = 0;
        e.t  = 0;
        e.tg = 0;
        for (int w = 0; w < NW; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == tg) begin
                e.h  = 1;
                e.t  = (m_ctr[s][w] >= 2);
                e.tg = m_tgt[s][w];
            end
        end
    endtask

    task automatic m_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
        int s;
        int hw;
        int vw;
        logic [31:0] tg;
        s  = int'((pc >> 2) % NS);
        tg = pc >> (2 + IDXW);
        hw = -1;
        for (int w = 0; w < NW; w++)
            if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
        if (hw >= 0) begin
            if (tk) begin
                m_ctr[s][hw] = (m_ctr[s][hw] < 3) ? m_ctr[s][hw] + 1 : 3;
                m_tgt[s][hw] = tgt & ~32'd3;
            end else begin
                m_ctr[s][hw] = (m_ctr[s][hw] > 0) ? m_ctr[s][hw] - 1 : 0;
            end
        end else if (tk) begin
            vw = -1;
            for (int w = NW - 1; w >= 0; w--)
                if (!m_valid[s][w]) vw = w;
            if (vw < 0) begin
                vw      = m_rr[s];
                m_rr[s] = (m_rr[s] + 1) % NW;
            end
            m_valid[s][vw] = 1;
            m_tag[s][vw]   = tg;
            m_tgt[s][vw]   = tgt & ~32'd3;
            m_ctr[s][vw]   = 2;
        end
    endtask

    // One clock of stimulus; expected response queued before the model advances.
    task automatic cyc(input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utg, input bit ut,
                       input bit fl);
        exp_t e;
        bif.lookup_valid_i = lv;
        bif.lookup_pc_i    = lpc;
        bif.upd_valid_i    = uv;
        bif.upd_pc_i       = upc;
        bif.upd_target_i   = utg;
        bif.upd_taken_i    = ut;
        bif.flush_i        = fl;
        if (lv) m_lookup(lpc, e);
        else begin
            e.v = 0; e.h = 0; e.t = 0; e.tg = 0;
        end
        q.push_back(e);
        if (fl) m_clear();
        else if (uv) m_update(upc, utg, ut);
        @(negedge clk_i);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(1, pc, 0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tg, input bit tk);
        cyc(0, 0, 1, pc, tg, tk, 0);
    endtask

    // Monitor: pops one expectation per captured cycle and compares the prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (arst_ni) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("valid_o",  32'(bif.lookup_valid_o), 32'(e.v));
                    chk("hit_o",    32'(bif.lookup_hit_o),   32'(e.h));
                    chk("taken_o",  32'(bif.lookup_taken_o), 32'(e.t));
                    chk("target_o", bif.lookup_target_o,     e.tg);
                end else begin
                    chk("idle_valid_o", 32'(bif.lookup_valid_o), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] pc_a;
        logic [31:0] pc_b;
        bit lv;
        bit uv;
        bit ut;
        bit fl;

        bif.flush_i        = 0;
        bif.lookup_valid_i = 0;
        bif.lookup_pc_i    = 0;
        bif.upd_valid_i    = 0;
        bif.upd_pc_i       = 0;
        bif.upd_target_i   = 0;
        bif.upd_taken_i    = 0;
        m_clear();

        #12;
        chk("rst_valid_o",  32'(bif.lookup_valid_o), 32'd0);
        chk("rst_hit_o",    32'(bif.lookup_hit_o),   32'd0);
        chk("rst_taken_o",  32'(bif.lookup_taken_o), 32'd0);
        chk("rst_target_o", bif.lookup_target_o,     32'd0);
        @(negedge clk_i);
        arst_ni = 1;

        // Miss after reset, then allocate and hit.
        look(32'h1000);
        upd(32'h1000, 32'h2000, 1);
        look(32'h1000);
        // Counter walks down to strongly not-taken, then saturates up.
        upd(32'h1000, 32'h2000, 0);
        look(32'h1000);
        upd(32'h1000, 32'h2000, 0);
        look(32'h1000);
        upd(32'h1000, 32'h2000, 0);
        look(32'h1000);
        upd(32'h1000, 32'h2004, 1);
        upd(32'h1000, 32'h2008, 1);
        upd(32'h1000, 32'h200F, 1);
        look(32'h1000);
        upd(32'h1000, 32'h2010, 1);
        look(32'h1000);
        // Same-set replacement.
        upd(32'h1040, 32'h5000, 1);
        upd(32'h1080, 32'h6000, 1);
        look(32'h1000);
        look(32'h1040);
        look(32'h1080);
        upd(32'h10C0, 32'h7000, 1);
        look(32'h1040);
        look(32'h1080);
        look(32'h10C0);
        // Not-taken miss does not allocate; lookup_valid_i low gives zeros.
        upd(32'h2200, 32'h9000, 0);
        look(32'h2200);
        cyc(0, 32'h1080, 0, 0, 0, 0, 0);
        // Same-cycle allocate and lookup: read-before-write.
        cyc(1, 32'h3000, 1, 32'h3000, 32'h3100, 1, 0);
        look(32'h3000);
        // Flush beats a same-cycle update; lookup in flush cycle sees old contents.
        cyc(1, 32'h3000, 1, 32'h4000, 32'h4400, 1, 1);
        look(32'h3000);
        look(32'h4000);
        look(32'h1080);
        upd(32'h1000, 32'h2000, 1);
        look(32'h1000);

        // Random traffic over a few sets with many aliasing tags.
        for (int i = 0; i < 2000; i++) begin
            pc_a = 32'h1000 | (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2);
            pc_b = 32'h1000 | (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 3)) << 2)
                   | 32'($urandom_range(0, 3));
            lv = ($urandom_range(0, 3) != 0);
            uv = ($urandom_range(0, 1) != 0);
            ut = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 49) == 0);
            cyc(lv, pc_a, uv, pc_b, $urandom, ut, fl);
        end

        // Asynchronous reset in mid-operation.
        upd(32'h1000, 32'h2000, 1);
        look(32'h1000);
        bif.lookup_valid_i = 0;
        bif.upd_valid_i    = 0;
        #2;
        arst_ni = 0;
        q.delete();
        m_clear();
        #1;
        chk("arst_valid_o",  32'(bif.lookup_valid_o), 32'd0);
        chk("arst_hit_o",    32'(bif.lookup_hit_o),   32'd0);
        chk("arst_target_o", bif.lookup_target_o,     32'd0);
        @(negedge clk_i);
        arst_ni = 1;
        look(32'h1000);
        cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
